// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-RAM boot loader.
//   LEN_W    : width of the little-endian length header (words to load)
//   state_e  : loader FSM states
//   rx_state : states in which the loader accepts bytes
package imem_boot_loader_pkg;

  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  function automatic logic rx_state(input state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Bus bundle between the boot loader and its environment.
//   start/rx_*        : control pulse and byte stream into the loader
//   core_pc/core_re   : core fetch request (passed to RAM while loader idle)
//   mem_*             : instruction RAM address/write port
//   core_hold, load_* : status back to the core / system
//   word_cnt          : words written in the current/last load
// slave = loader side, master = environment side.
interface imem_boot_loader_if #(
  parameter int unsigned W = 32,
  parameter int unsigned H = 8
) ();
  logic         start;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [W-1:0] core_pc;
  logic         core_re;
  logic [W-1:0] mem_pc;
  logic         mem_re;
  logic         mem_we;
  logic [W-1:0] mem_wdata;
  logic         core_hold;
  logic         load_done;
  logic         load_err;
  logic [H:0]   word_cnt;

  modport slave (
    input  start, rx_data, rx_valid, core_pc, core_re,
    output rx_ready, mem_pc, mem_re, mem_we, mem_wdata,
           core_hold, load_done, load_err, word_cnt
  );

  modport master (
    output start, rx_data, rx_valid, core_pc, core_re,
    input  rx_ready, mem_pc, mem_re, mem_we, mem_wdata,
           core_hold, load_done, load_err, word_cnt
  );
endinterface

// File: rtl/imem_boot_loader_packer.sv
// imem_byte_packer: assembles W-bit little-endian words from a byte stream.
//   clk, rst   : clock, async active-high reset
//   clear      : restart at lane 0 with an all-zero word
//   byte_valid : byte_in is consumed this cycle into lane byte_idx
//   byte_in    : incoming byte
//   word       : packed word register (lane 0 = bits [7:0])
//   word_full  : the byte consumed this cycle completes the word
module imem_byte_packer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         byte_valid,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] word,
  output logic         word_full
);

  localparam int unsigned LANES = W / 8;
  localparam int unsigned IDXW  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IDXW-1:0] byte_idx_q, byte_idx_d;
  logic [W-1:0]    word_q, word_d;

  always_comb begin
    word_full  = byte_valid && (byte_idx_q == IDXW'(LANES - 1));
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    if (clear) begin
      byte_idx_d = '0;
      word_d     = '0;
    end else if (byte_valid) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (byte_idx_q == IDXW'(i)) word_d[i*8 +: 8] = byte_in;
      end
      byte_idx_d = word_full ? '0 : byte_idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot/reload controller for a 2**H x W instruction RAM.
// Takes a 16-bit little-endian word count followed by little-endian words
// over a byte stream, writes them to RAM from address 0 while holding the
// core, and hands the RAM address port back to core fetch when idle.
//   clk, rst : clock, async active-high reset (sync release expected)
//   bus      : imem_boot_loader_if.slave (stream, fetch, RAM port, status)
// BOOT_HOLD=1 makes reset wait for a load before releasing the core.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned H         = 8,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  imem_boot_loader_if.slave bus
);

  localparam state_e          RESET_STATE = BOOT_HOLD ? ST_LEN0 : ST_IDLE;
  localparam logic [LEN_W:0]  CAPACITY    = (LEN_W + 1)'(1) << H;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [H:0]       word_idx_q, word_idx_d;
  logic [H:0]       word_cnt_q, word_cnt_d;
  logic             rx_ready_q, rx_ready_d;
  logic             core_hold_q, core_hold_d;
  logic             mem_we_q, mem_we_d;
  logic             load_done_q, load_done_d;
  logic             load_err_q, load_err_d;

  logic             rx_fire;
  logic             restart;
  logic [LEN_W-1:0] len_full;
  logic [H:0]       next_idx;
  logic             last_word;
  logic             pack_clear;
  logic             pack_valid;
  logic             word_full;
  logic [W-1:0]     packed_word;
  logic [W-1:0]     loader_pc;

  assign rx_fire   = bus.rx_valid && rx_ready_q;
  assign restart   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_ERR));
  assign len_full  = {bus.rx_data, count_q[7:0]};
  assign next_idx  = word_idx_q + (H + 1)'(1);
  assign last_word = (LEN_W'(next_idx) == count_q);
  assign pack_valid = rx_fire && (state_q == ST_DATA);

  imem_byte_packer #(
    .W (W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_in    (bus.rx_data),
    .word       (packed_word),
    .word_full  (word_full)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_LEN0;
      ST_LEN0:  if (rx_fire) state_d = ST_LEN1;
      ST_LEN1: begin
        if (rx_fire) begin
          if (len_full == '0)                    state_d = ST_IDLE;
          else if ({1'b0, len_full} > CAPACITY)  state_d = ST_ERR;
          else                                   state_d = ST_DATA;
        end
      end
      ST_DATA:  if (word_full) state_d = ST_WRITE;
      ST_WRITE: state_d = last_word ? ST_IDLE : ST_DATA;
      ST_ERR:   if (bus.start) state_d = ST_LEN0;
      default:  state_d = RESET_STATE;
    endcase
  end

  // Outputs and datapath next values. Registered outputs are derived from
  // state_d so they line up with the state they describe.
  always_comb begin
    count_d    = count_q;
    word_idx_d = word_idx_q;
    word_cnt_d = word_cnt_q;
    pack_clear = 1'b0;

    if (restart) word_cnt_d = '0;

    if (rx_fire && (state_q == ST_LEN0)) count_d[7:0] = bus.rx_data;
    if (rx_fire && (state_q == ST_LEN1)) begin
      count_d[LEN_W-1:8] = bus.rx_data;
      word_idx_d         = '0;
      pack_clear         = 1'b1;
    end
    if (state_q == ST_WRITE) begin
      word_idx_d = next_idx;
      word_cnt_d = word_cnt_q + (H + 1)'(1);
    end

    rx_ready_d  = rx_state(state_d);
    core_hold_d = (state_d != ST_IDLE);
    mem_we_d    = (state_d == ST_WRITE);
    load_err_d  = (state_d == ST_ERR);
    load_done_d = (state_d == ST_IDLE) &&
                  ((state_q == ST_LEN1) || (state_q == ST_WRITE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      word_idx_q  <= '0;
      word_cnt_q  <= '0;
      rx_ready_q  <= BOOT_HOLD;
      core_hold_q <= BOOT_HOLD;
      mem_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      word_cnt_q  <= word_cnt_d;
      rx_ready_q  <= rx_ready_d;
      core_hold_q <= core_hold_d;
      mem_we_q    <= mem_we_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // RAM address port: core fetch passes straight through only while idle.
  always_comb begin
    loader_pc          = '0;
    loader_pc[H+2:0]   = {word_idx_q, 2'b00};
  end

  assign bus.mem_pc    = (state_q == ST_IDLE) ? bus.core_pc : loader_pc;
  assign bus.mem_re    = (state_q == ST_IDLE) ? bus.core_re : 1'b0;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = packed_word;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.core_hold = core_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;
  assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int unsigned W = 32;
  localparam int unsigned H = 8;

  logic clk;
  logic rst;

  imem_boot_loader_if #(.W(W), .H(H)) bus ();

  imem_boot_loader #(
    .W         (W),
    .H         (H),
    .BOOT_HOLD (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // RAM write log, captured away from the active edge.
  logic [W-1:0] wr_addr [16];
  logic [W-1:0] wr_data [16];
  int unsigned  wr_n = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 && wr_n < 16) begin
      wr_addr[wr_n] = bus.mem_pc;
      wr_data[wr_n] = bus.mem_wdata;
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept_timeout", 64'(n < 50), 64'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n;
    n = 0;
    while (bus.load_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(bus.load_done), 64'd1);
  endtask

  task automatic idle_cycles(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.core_pc  = '0;
    bus.core_re  = 1'b0;

    // 1: reset state (BOOT_HOLD=1)
    idle_cycles(3);
    check("rst_core_hold", 64'(bus.core_hold), 64'd1);
    check("rst_rx_ready",  64'(bus.rx_ready),  64'd1);
    check("rst_mem_we",    64'(bus.mem_we),    64'd0);
    check("rst_load_err",  64'(bus.load_err),  64'd0);
    check("rst_load_done", 64'(bus.load_done), 64'd0);
    check("rst_word_cnt",  64'(bus.word_cnt),  64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rx_ready", 64'(bus.rx_ready), 64'd1);

    // 2: two-word load
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    wait_done("load2_done");
    check("load2_core_hold", 64'(bus.core_hold), 64'd0);
    check("load2_word_cnt",  64'(bus.word_cnt),  64'd2);
    check("load2_wr_n",      64'(wr_n),          64'd2);
    check("load2_addr0",     64'(wr_addr[0]),    64'h0);
    check("load2_data0",     64'(wr_data[0]),    64'h00000013);
    check("load2_addr1",     64'(wr_addr[1]),    64'h4);
    check("load2_data1",     64'(wr_data[1]),    64'h00100093);
    @(negedge clk);
    check("load2_done_pulse", 64'(bus.load_done), 64'd0);
    check("idle_rx_ready",    64'(bus.rx_ready),  64'd0);
    bus.core_pc = 32'h4;
    bus.core_re = 1'b1;
    #1;
    check("idle_mem_pc", 64'(bus.mem_pc), 64'h4);
    check("idle_mem_re", 64'(bus.mem_re), 64'd1);
    @(negedge clk);

    // 3: oversize header -> ERR
    pulse_start();
    check("len0_core_hold", 64'(bus.core_hold), 64'd1);
    check("len0_mem_re",    64'(bus.mem_re),    64'd0);
    check("len0_mem_pc",    64'(bus.mem_pc),    64'h8);
    check("len0_word_cnt",  64'(bus.word_cnt),  64'd0);
    bus.core_re = 1'b0;
    send_byte(8'h01); send_byte(8'h01);
    check("err_load_err",  64'(bus.load_err),  64'd1);
    check("err_core_hold", 64'(bus.core_hold), 64'd1);
    check("err_rx_ready",  64'(bus.rx_ready),  64'd0);
    idle_cycles(2);
    check("err_no_write",  64'(wr_n),          64'd2);
    pulse_start();
    check("err_clr_load_err", 64'(bus.load_err), 64'd0);
    check("err_clr_rx_ready", 64'(bus.rx_ready), 64'd1);

    // 4: zero-length header, then a load with rx_valid gaps
    send_byte(8'h00); send_byte(8'h00);
    check("zero_load_done", 64'(bus.load_done), 64'd1);
    check("zero_core_hold", 64'(bus.core_hold), 64'd0);
    check("zero_word_cnt",  64'(bus.word_cnt),  64'd0);
    check("zero_no_write",  64'(wr_n),          64'd2);
    @(negedge clk);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); idle_cycles(3);
    send_byte(8'h56); idle_cycles(2);
    send_byte(8'h34); send_byte(8'h12);
    wait_done("gap_done");
    check("gap_wr_n",     64'(wr_n),        64'd3);
    check("gap_addr",     64'(wr_addr[2]),  64'h0);
    check("gap_data",     64'(wr_data[2]),  64'h12345678);
    check("gap_word_cnt", 64'(bus.word_cnt), 64'd1);
    @(negedge clk);

    // 5: reset mid-load, then restart from word 0
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    check("mid_word_cnt", 64'(bus.word_cnt), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_word_cnt",  64'(bus.word_cnt),  64'd0);
    check("mid_rst_rx_ready",  64'(bus.rx_ready),  64'd1);
    check("mid_rst_core_hold", 64'(bus.core_hold), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_done("restart_done");
    check("restart_wr_n",   64'(wr_n),       64'd5);
    check("partial_data",   64'(wr_data[3]), 64'h44332211);
    check("restart_addr",   64'(wr_addr[4]), 64'h0);
    check("restart_data",   64'(wr_data[4]), 64'hDDCCBBAA);
    check("restart_cnt",    64'(bus.word_cnt), 64'd1);
    @(negedge clk);

    // 6: start during DATA is ignored
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    pulse_start();
    check("ign_load_err", 64'(bus.load_err), 64'd0);
    send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    wait_done("ign_done");
    check("ign_word_cnt", 64'(bus.word_cnt), 64'd2);
    check("ign_wr_n",     64'(wr_n),         64'd7);
    check("ign_data0",    64'(wr_data[5]),   64'h04030201);
    check("ign_addr1",    64'(wr_addr[6]),   64'h4);
    check("ign_data1",    64'(wr_data[6]),   64'h08070605);
    @(negedge clk);

    // Boundary: exactly 2**H words is accepted
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    check("cap_load_err",  64'(bus.load_err),  64'd0);
    check("cap_rx_ready",  64'(bus.rx_ready),  64'd1);
    check("cap_core_hold", 64'(bus.core_hold), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
